// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver.
// Frame: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stops.
// A 2-flop synchroniser feeds rxs. All decisions are made on baud_tick.
// Optional build macro UART_RX_MAJORITY_EN: each sample point votes 2-of-3 over
// ticks mid-1/mid/mid+1, and the decision is taken at mid+1.
module uart_rx_param #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 break_detect,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE) + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Tick-counter value on which a sample decision is taken.
  localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2 - 1 + MAJ);
  localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP  = 4'(STOP_BITS - 1);
  localparam logic          ODD        = (PARITY == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  logic                 sync1_q, rxs_q, rxs_prev_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ones_q, ones_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d, pe_q, pe_d, fe_q, fe_d, bd_q, bd_d;
  logic [TW-1:0]        dec_t;
  logic                 at_dec, sample, stop_fe, stop_ones;

  assign dec_t     = (state_q == S_START) ? START_LAST : BIT_LAST;
  assign at_dec    = (tick_q == dec_t);
  assign stop_fe   = ferr_q | ~sample;
  assign stop_ones = ones_q | sample;

  // Two-flop synchroniser; rxs_prev tracks rxs at the previous baud tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
      if (baud_tick) rxs_prev_q <= rxs_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic m0_q, m1_q;
  // Capture the two early votes (ticks mid-1 and mid) of each sample window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m0_q <= 1'b1;
      m1_q <= 1'b1;
    end else if (baud_tick) begin
      if (tick_q == dec_t - TW'(2)) m0_q <= rxs_q;
      if (tick_q == dec_t - TW'(1)) m1_q <= rxs_q;
    end
  end
  assign sample = maj3(m0_q, m1_q, rxs_q);
`else
  assign sample = rxs_q;
`endif

  // Frame state machine; everything advances only on baud_tick.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ones_d  = ones_q;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    dv_d    = 1'b0;
    bd_d    = 1'b0;
    if (baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (rxs_prev_q && !rxs_q) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (at_dec) begin
            if (sample) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
              par_d   = 1'b0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
              ones_d  = 1'b0;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (at_dec) begin
            tick_d  = '0;
            shift_d = {sample, shift_q[DATA_BITS-1:1]};
            par_d   = par_q ^ sample;
            ones_d  = ones_q | sample;
            if (bit_q == LAST_DATA) begin
              bit_d   = '0;
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_PARITY: begin
          if (at_dec) begin
            tick_d  = '0;
            perr_d  = ((par_q ^ sample) != ODD);
            ones_d  = ones_q | sample;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_STOP: begin
          if (at_dec) begin
            tick_d = '0;
            ferr_d = stop_fe;
            ones_d = stop_ones;
            if (bit_q == LAST_STOP) begin
              // Frame complete: publish word and flags together.
              bit_d   = '0;
              data_d  = shift_q;
              pe_d    = perr_q;
              fe_d    = stop_fe;
              dv_d    = 1'b1;
              bd_d    = ~stop_ones;
              state_d = stop_fe ? S_WAIT : S_IDLE;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_WAIT: begin
          if (rxs_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ones_q  <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ones_q  <= ones_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      bd_q    <= bd_d;
    end
  end

  assign data         = data_q;
  assign data_valid   = dv_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign break_detect = bd_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: three instances (8N1, 8E1, 7N2 on a /4 tick),
// frames built bit by bit and checked against a frame-level reference model.
module tb_uart_rx_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rxl   = 3'b111;
  logic       tick2 = 1'b0;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [2:0] dv, pe, fe, bd, bz;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cnt[3];
  int lcyc[3];
  int fall_cyc[3];
  logic [8:0] ld[3];
  logic lpe[3], lfe[3], lbd[3];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_rx_param #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clock(clock), .reset(reset), .baud_tick(1'b1), .rx(rxl[0]), .data(d0),
    .data_valid(dv[0]), .parity_error(pe[0]), .frame_error(fe[0]),
    .break_detect(bd[0]), .busy(bz[0]));

  uart_rx_param #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clock(clock), .reset(reset), .baud_tick(1'b1), .rx(rxl[1]), .data(d1),
    .data_valid(dv[1]), .parity_error(pe[1]), .frame_error(fe[1]),
    .break_detect(bd[1]), .busy(bz[1]));

  uart_rx_param #(.OVERSAMPLE(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
    .clock(clock), .reset(reset), .baud_tick(tick2), .rx(rxl[2]), .data(d2),
    .data_valid(dv[2]), .parity_error(pe[2]), .frame_error(fe[2]),
    .break_detect(bd[2]), .busy(bz[2]));

  // Strobe monitor: counts data_valid pulses and latches what came with them.
  always @(negedge clock) begin
    if (dv[0]) begin
      cnt[0]++; lcyc[0] = cyc; ld[0] = {1'b0, d0}; lpe[0] = pe[0]; lfe[0] = fe[0]; lbd[0] = bd[0];
    end
    if (dv[1]) begin
      cnt[1]++; lcyc[1] = cyc; ld[1] = {1'b0, d1}; lpe[1] = pe[1]; lfe[1] = fe[1]; lbd[1] = bd[1];
    end
    if (dv[2]) begin
      cnt[2]++; lcyc[2] = cyc; ld[2] = {2'b0, d2}; lpe[2] = pe[2]; lfe[2] = fe[2]; lbd[2] = bd[2];
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Tick every 4th clock for the third instance.
  initial begin
    int div;
    div = 0;
    forever begin
      wclk(1);
      tick2 = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Serialise one frame onto line inst, then leave the line at gap_lvl.
  task automatic send(input int inst, input int nbits, input logic [8:0] d,
                      input bit has_par, input logic pbit, input int nstop,
                      input logic [1:0] stops, input int bitclk,
                      input logic gap_lvl, input int gap);
    logic [12:0] bits;
    int n;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nbits; i++) begin bits[n] = d[i]; n++; end
    if (has_par) begin bits[n] = pbit; n++; end
    for (int i = 0; i < nstop; i++) begin bits[n] = stops[i]; n++; end
    fall_cyc[inst] = cyc;
    for (int i = 0; i < n; i++) begin
      rxl[inst[1:0]] = bits[i];
      wclk(bitclk);
    end
    rxl[inst[1:0]] = gap_lvl;
    wclk(gap);
  endtask

  // Send a frame and compare the strobe against the frame-level model.
  task automatic run_frame(input int inst, input int nbits, input logic [8:0] d,
                           input bit has_par, input bit odd, input logic pbit,
                           input logic [1:0] stops, input int nstop,
                           input int bitclk, input string tag);
    int c0;
    logic [8:0] ed;
    logic epe, efe, ebd;
    c0 = cnt[inst];
    send(inst, nbits, d, has_par, pbit, nstop, stops, bitclk, 1'b1, bitclk);
    ed  = d & ((9'h1 << nbits) - 9'h1);
    epe = has_par && ((^ed ^ pbit) != odd);
    efe = !stops[0] || (nstop == 2 && !stops[1]);
    ebd = (ed == 0) && (!has_par || !pbit) && !stops[0] && (nstop == 1 || !stops[1]);
    chk({tag, ".strobes"}, cnt[inst] - c0, 1);
    chk({tag, ".data"}, int'(ld[inst]), int'(ed));
    chk({tag, ".parity_error"}, int'(lpe[inst]), int'(epe));
    chk({tag, ".frame_error"}, int'(lfe[inst]), int'(efe));
    chk({tag, ".break_detect"}, int'(lbd[inst]), int'(ebd));
    chk({tag, ".busy_after"}, int'(bz[inst]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] rd;
    logic [1:0] st;
    logic pb;
    int c0, lat;

    // Reset state.
    wclk(3);
    chk("rst.data0", int'(d0), 0);
    chk("rst.data2", int'(d2), 0);
    chk("rst.valid", int'(dv), 0);
    chk("rst.flags", int'({pe, fe, bd}), 0);
    chk("rst.busy", int'(bz), 0);
    reset = 1'b0;
    wclk(5);

    // 8N1 0xA5 with latency window.
    run_frame(0, 8, 9'hA5, 0, 0, 0, 2'b11, 1, 16, "a5");
    lat = lcyc[0] - fall_cyc[0];
    chk("a5.latency_in_153_155", int'(lat >= 153 && lat <= 155), 1);

    // Glitch shorter than half a bit is rejected.
    c0 = cnt[0];
    rxl[0] = 1'b0; wclk(5);
    rxl[0] = 1'b1; wclk(3);
    chk("glitch.busy_mid", int'(bz[0]), 1);
    wclk(30);
    chk("glitch.no_strobe", cnt[0] - c0, 0);
    chk("glitch.busy_after", int'(bz[0]), 0);
    run_frame(0, 8, 9'h5A, 0, 0, 0, 2'b11, 1, 16, "after_glitch");

    // Break: line low for 40 bit times gives a single strobe.
    c0 = cnt[0];
    rxl[0] = 1'b0; wclk(640);
    chk("break.busy_held", int'(bz[0]), 1);
    rxl[0] = 1'b1; wclk(32);
    chk("break.strobes", cnt[0] - c0, 1);
    chk("break.data", int'(ld[0]), 0);
    chk("break.frame_error", int'(lfe[0]), 1);
    chk("break.break_detect", int'(lbd[0]), 1);
    chk("break.busy_after", int'(bz[0]), 0);
    run_frame(0, 8, 9'h7E, 0, 0, 0, 2'b11, 1, 16, "after_break");

    // Reset in the middle of data bit 3 of a 0xC3 frame.
    c0 = cnt[0];
    rxl[0] = 1'b0; wclk(16);
    rxl[0] = 1'b1; wclk(16);
    rxl[0] = 1'b1; wclk(16);
    rxl[0] = 1'b0; wclk(16);
    rxl[0] = 1'b0; wclk(8);
    reset = 1'b1;
    #1;
    chk("midrst.data", int'(d0), 0);
    chk("midrst.busy", int'(bz[0]), 0);
    chk("midrst.valid", int'(dv[0]), 0);
    rxl[0] = 1'b1;
    wclk(3);
    reset = 1'b0;
    wclk(160);
    chk("midrst.no_strobe", cnt[0] - c0, 0);
    run_frame(0, 8, 9'hC3, 0, 0, 0, 2'b11, 1, 16, "after_rst");

    // Random 8N1 traffic, occasional bad stop bit.
    for (int i = 0; i < 12; i++) begin
      rd = 9'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
      run_frame(0, 8, rd, 0, 0, 0, st, 1, 16, "u0.rand");
    end

    // Even parity.
    run_frame(1, 8, 9'h03, 1, 0, 1'b0, 2'b11, 1, 16, "par_ok");
    run_frame(1, 8, 9'h03, 1, 0, 1'b1, 2'b11, 1, 16, "par_bad");
    for (int i = 0; i < 8; i++) begin
      rd = 9'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b11;
      run_frame(1, 8, rd, 1, 0, pb, st, 1, 16, "u1.rand");
    end

    // 7 data bits, 2 stop bits, tick every 4th clock: second stop bit low.
    c0 = cnt[2];
    send(2, 7, 9'h55, 0, 1'b0, 2, 2'b01, 64, 1'b0, 128);
    chk("s2.strobes", cnt[2] - c0, 1);
    chk("s2.data", int'(ld[2]), 'h55);
    chk("s2.frame_error", int'(lfe[2]), 1);
    chk("s2.break_detect", int'(lbd[2]), 0);
    chk("s2.busy_wait_idle", int'(bz[2]), 1);
    rxl[2] = 1'b1; wclk(64);
    chk("s2.busy_released", int'(bz[2]), 0);
    chk("s2.no_extra_strobe", cnt[2] - c0, 1);
    for (int i = 0; i < 6; i++) begin
      rd = 9'($urandom_range(0, 127));
      st = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) st = 2'b11;
      run_frame(2, 7, rd, 0, 0, 0, st, 2, 64, "u2.rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised asynchronous serial receiver; next generation of the fixed 8N1, 16x-oversampled receiver in the photo-frame FPGA image path.
- Generalised in oversample ratio, data width, parity mode and stop-bit count.
- Adds an input synchroniser, false-start rejection, a parity check, break detection and an external oversample-tick enable.
- Feeds the byte/command parser. Delivers one word per frame with a single-cycle valid strobe.

Parameters:
- OVERSAMPLE, 16: ticks per bit. Legal range is 4..64; the value must be even.
- DATA_BITS, 8: data bits per frame. Legal range is 5..9. Bits are sent LSB first.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- baud_tick  in  1  oversample enable. Counters advance only when this is high. Tie it to 1 to oversample at the clock rate.
- rx  in  1  serial line; idles high.
- data  out  DATA_BITS  last received word.
- data_valid  out  1  one-clock strobe when a frame completes.
- parity_error  out  1  parity status of the last frame.
- frame_error  out  1  a stop bit sampled low in the last frame.
- break_detect  out  1  one-clock strobe, issued together with data_valid, for a break frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE from any state, including mid-frame. The partial frame is discarded and no strobe is issued.
  - Synchroniser flops reset to 1.
  - data = 0; data_valid, parity_error, frame_error, break_detect and busy = 0.
  - Tick counter and bit counter = 0.
- Input: rx passes through a 2-flop synchroniser to give rxs. All decisions use rxs, so there are 2 clocks of input latency.
- The tick counter increments only on clocks where baud_tick = 1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE:
    - Start detection uses a registered falling edge on rxs (rxs_prev = 1, rxs = 0) that is evaluated only on a baud_tick.
    - On detection, clear the tick counter and enter START.
  - START:
    - After OVERSAMPLE/2 ticks, sample rxs.
    - rxs = 1: false start. Return to IDLE; no strobe and no flags change.
    - rxs = 0: clear the tick counter and the bit counter, then enter DATA.
  - DATA:
    - Sample every OVERSAMPLE ticks, which lands at mid-bit.
    - Shift into a shift register LSB first and accumulate XOR parity.
    - After DATA_BITS samples, go to PARITY if PARITY != 0, otherwise to STOP.
  - PARITY:
    - Sample one bit.
    - The error condition is (xor_of_data ^ sampled_bit) != (PARITY == 2 ? 1 : 0).
  - STOP:
    - Sample STOP_BITS bits, each OVERSAMPLE ticks apart.
    - frame_error is set if any sampled stop bit is 0.
- Frame completion is the clock after the last stop sample. On that clock:
  - data, parity_error and frame_error update together.
  - data_valid = 1 for exactly one clock.
  - break_detect = 1 if every data bit, the parity bit (if any) and every stop bit were 0.
- Flags and data hold until the next completion. They are not sticky across frames.
- After completion: if frame_error, go to WAIT_IDLE; otherwise go to IDLE.
  - In the no-error case, sampling at mid-stop re-arms half a bit early, which tolerates up to about 4.5% baud mismatch.
- WAIT_IDLE: stay until rxs = 1 on a baud_tick, then go to IDLE. A held-low line (break) therefore yields exactly one strobe.
- baud_tick low for any number of clocks freezes all counters. State and outputs hold, and no strobe is generated.
- Counter widths: tick counter is clog2(OVERSAMPLE) + 1 bits; bit counter is 4 bits.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- When defined: every sample point (start, data, parity, stop) takes the 2-of-3 majority of rxs at ticks mid-1, mid and mid+1. The decision is registered at tick mid+1, so each state's exit is delayed by one tick and the next bit's timing stays anchored to the start edge.
- When undefined: a single sample is taken at tick mid.
- Port list and strobe timing relative to the final stop sample are unchanged in both builds.

Test Plan:
- OVERSAMPLE=16, 8N1, baud_tick=1; send 0xA5 -> data=8'hA5 and one data_valid pulse 16*9+8+2 (±1) clocks after the rx fall; all error flags 0; busy low afterwards.
- PARITY=1, send 0x03 with parity bit 0, then 0x03 with parity bit 1 -> first frame parity_error=0, second parity_error=1, data=8'h03 both times.
- 8N1, glitch rx low for 5 clocks then high -> START rejects at tick 8; no data_valid; busy returns low; a following 0x5A frame is received correctly.
- Hold rx low for 40 bit times, then release -> exactly one data_valid with data=0, frame_error=1, break_detect=1; the next 0x7E frame is received with frame_error=0.
- STOP_BITS=2, DATA_BITS=7, baud_tick every 4th clock; send 0x55 with second stop bit 0 -> data=7'h55, frame_error=1, WAIT_IDLE until line high.
- Assert reset during data bit 3 of a frame -> outputs 0 immediately, no strobe for the aborted frame; a clean 0xC3 frame after release yields data=8'hC3.
